// File: rtl/team_05_arb_pkg.sv
// Shared types and constants for the team_05 two-requester Wishbone master arbiter.
package team_05_arb_pkg;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned ADR_W   = 32;
  localparam int unsigned DAT_W   = 32;
  localparam int unsigned SEL_W   = 4;

  // Read data returned on a timed-out transaction.
  localparam logic [DAT_W-1:0] RDATA_ERR = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } state_t;

  // Operands of one requester's Wishbone transaction.
  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic             we;
  } wb_req_t;

endpackage

// File: rtl/team_05_rr_arb2.sv
// Two-way round-robin grant logic (combinational).
//   req        : request levels of requesters 1..0
//   last_grant : index of the requester granted most recently
//   gnt        : one-hot grant, all zero when nothing is requested
module team_05_rr_arb2
  import team_05_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] gnt
);

  // A tie goes to the requester that was not served last.
  always_comb begin
    gnt = '0;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/team_05_wb_master_arbiter.sv
// Shares one Wishbone master port between requester 0 (fetch) and
// requester 1 (data). Round-robin, one transaction in flight, bus timeout
// answered with an error completion.
//   clk_i, rst_i          : clock, synchronous active-high reset
//   mN_req_i/adr/dat/sel/we: requester N transaction request and operands
//   mN_done_o/err_o/rdata_o: requester N completion pulse, timeout flag, read data
//   ADR_O..CYC_O, DAT_I, ACK_I : Wishbone master port
//   busy_o                : high while a transaction is on the bus or responding
module team_05_wb_master_arbiter
  import team_05_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             m0_req_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  input  logic [SEL_W-1:0] m0_sel_i,
  input  logic             m0_we_i,
  output logic             m0_done_o,
  output logic             m0_err_o,
  output logic [DAT_W-1:0] m0_rdata_o,
  input  logic             m1_req_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  input  logic [SEL_W-1:0] m1_sel_i,
  input  logic             m1_we_i,
  output logic             m1_done_o,
  output logic             m1_err_o,
  output logic [DAT_W-1:0] m1_rdata_o,
  output logic [ADR_W-1:0] ADR_O,
  output logic [DAT_W-1:0] DAT_O,
  output logic [SEL_W-1:0] SEL_O,
  output logic             WE_O,
  output logic             STB_O,
  output logic             CYC_O,
  input  logic [DAT_W-1:0] DAT_I,
  input  logic             ACK_I,
  output logic             busy_o
);

  state_t             state;
  logic               last_grant;
  logic               gnt_idx;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] done_q;
  logic [NUM_REQ-1:0] err_q;
  logic [DAT_W-1:0]   rdata_q [NUM_REQ];

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  wb_req_t            op0;
  wb_req_t            op1;
  wb_req_t            op_sel;
  logic               timeout_hit;

  assign req = {m1_req_i, m0_req_i};
  assign op0 = '{adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i, we: m0_we_i};
  assign op1 = '{adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i, we: m1_we_i};
  assign op_sel = gnt[1] ? op1 : op0;

  // Timeout comparison; a zero limit disables it entirely.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES));

  team_05_rr_arb2 u_arb (
    .req        (req),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // Arbitration FSM, timeout counter and registered bus/response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_idx    <= 1'b0;
      cnt        <= '0;
      done_q     <= '0;
      err_q      <= '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) rdata_q[i] <= '0;
      ADR_O      <= '0;
      DAT_O      <= '0;
      SEL_O      <= '0;
      WE_O       <= 1'b0;
      STB_O      <= 1'b0;
      CYC_O      <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            ADR_O      <= op_sel.adr;
            DAT_O      <= op_sel.dat;
            SEL_O      <= op_sel.sel;
            WE_O       <= op_sel.we;
            CYC_O      <= 1'b1;
            STB_O      <= 1'b1;
            last_grant <= gnt[1];
            gnt_idx    <= gnt[1];
            cnt        <= '0;
            busy_o     <= 1'b1;
            state      <= BUS;
          end
        end
        BUS: begin
          // ACK wins over a timeout landing in the same cycle.
          if (ACK_I || timeout_hit) begin
            done_q[gnt_idx]  <= 1'b1;
            err_q[gnt_idx]   <= !ACK_I;
            rdata_q[gnt_idx] <= (ACK_I && !WE_O) ? DAT_I : RDATA_ERR;
            ADR_O            <= '0;
            DAT_O            <= '0;
            SEL_O            <= '0;
            WE_O             <= 1'b0;
            CYC_O            <= 1'b0;
            STB_O            <= 1'b0;
            state            <= RESP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          done_q <= '0;
          err_q  <= '0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign m0_done_o  = done_q[0];
  assign m1_done_o  = done_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];

endmodule
